// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - FSM states, coin values and price lookup shared by vend_core_param
// The CHANGE state is only encoded when VEND_CHANGE_RETURN_EN is defined.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
`ifdef VEND_CHANGE_RETURN_EN
    VEND,
    CHANGE
`else
    VEND
`endif
  } vend_state_e;

  localparam int COIN_VAL [4] = '{1, 5, 10, 20};

  // Prices arrive as one packed vector; item idx sits at [idx*pw +: pw].
  function automatic int unsigned price_of(input logic [255:0] prices,
                                           input int unsigned idx,
                                           input int unsigned pw);
    logic [255:0] field;
    field = (prices >> (idx * pw)) & ((256'd1 << pw) - 256'd1);
    return field[31:0];
  endfunction

endpackage

// File: rtl/vend_edge_det.sv
// rtl/vend_edge_det.sv - rising-edge pulse generator, one history flop per input bit
module vend_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '0;
    else     hist_q <= din_i;
  end

  assign rise_o = din_i & ~hist_q;

endmodule

// File: rtl/vend_core_param.sv
// rtl/vend_core_param.sv - parametrised vending controller: capped credit, wrapping cursor, timed dispense
// Defining VEND_CHANGE_RETURN_EN adds refund_button/change_coin and the greedy CHANGE state.
module vend_core_param
  import vend_pkg::*;
#(
  parameter int                         N_ITEMS     = 5,
  parameter int                         PRICE_W     = 4,
  parameter logic [N_ITEMS*PRICE_W-1:0] PRICES      = {4'd8, 4'd10, 4'd6, 4'd5, 4'd7},
  parameter int                         CREDIT_W    = 7,
  parameter int                         MAX_CREDIT  = 79,
  parameter int                         VEND_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef VEND_CHANGE_RETURN_EN
  input  logic                       refund_button,
  output logic [3:0]                 change_coin,
`endif
  input  logic [3:0]                 coin_in,
  input  logic                       L_button,
  input  logic                       R_button,
  input  logic                       C_button,
  output logic [CREDIT_W-1:0]        credit,
  output logic [$clog2(N_ITEMS)-1:0] sel_idx,
  output logic [PRICE_W-1:0]         sel_price,
  output logic [N_ITEMS-1:0]         afford,
  output logic                       vend_valid,
  output logic [$clog2(N_ITEMS)-1:0] vend_idx,
  output logic                       coin_reject,
  output logic                       deny
);

  localparam int IDX_W = $clog2(N_ITEMS);
  localparam int CNT_W = $clog2(VEND_CYCLES + 1);
  localparam int SUM_W = CREDIT_W + 1;
`ifdef VEND_CHANGE_RETURN_EN
  localparam int EV_W = 8;
`else
  localparam int EV_W = 7;
`endif

  logic [EV_W-1:0]     in_vec, ev;
  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [IDX_W-1:0]    sel_q, sel_d, vidx_q, vidx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vend_q, vend_d, rej_q, rej_d, deny_q, deny_d;
  logic [PRICE_W-1:0]  price_arr [N_ITEMS];
  logic [PRICE_W-1:0]  cur_price;
  logic [SUM_W-1:0]    coin_add, coin_sum;
  logic [3:0]          coin_ev;
  logic                coin_multi, coin_block, l_ev, r_ev, c_ev, can_buy;
`ifdef VEND_CHANGE_RETURN_EN
  logic [3:0]          chg_q, chg_d;
  logic                f_ev;

  assign in_vec      = {refund_button, C_button, R_button, L_button, coin_in};
  assign f_ev        = ev[7];
  assign change_coin = chg_q;
`else
  assign in_vec = {C_button, R_button, L_button, coin_in};
`endif

  vend_edge_det #(.W(EV_W)) u_edge (
    .clk   (clk),
    .rst   (rst),
    .din_i (in_vec),
    .rise_o(ev)
  );

  assign coin_ev = ev[3:0];
  assign l_ev    = ev[4];
  assign r_ev    = ev[5];
  assign c_ev    = ev[6];

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_price
    assign price_arr[g] = PRICE_W'(price_of(256'(PRICES), g, PRICE_W));
    assign afford[g]    = credit_q >= CREDIT_W'(price_arr[g]);
  end

  assign cur_price   = price_arr[sel_q];
  assign can_buy     = credit_q >= CREDIT_W'(cur_price);
  assign sel_price   = cur_price;
  assign credit      = credit_q;
  assign sel_idx     = sel_q;
  assign vend_idx    = vidx_q;
  assign vend_valid  = vend_q;
  assign coin_reject = rej_q;
  assign deny        = deny_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      sel_q    <= '0;
      vidx_q   <= '0;
      cnt_q    <= '0;
      vend_q   <= 1'b0;
      rej_q    <= 1'b0;
      deny_q   <= 1'b0;
`ifdef VEND_CHANGE_RETURN_EN
      chg_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      sel_q    <= sel_d;
      vidx_q   <= vidx_d;
      cnt_q    <= cnt_d;
      vend_q   <= vend_d;
      rej_q    <= rej_d;
      deny_q   <= deny_d;
`ifdef VEND_CHANGE_RETURN_EN
      chg_q    <= chg_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    sel_d      = sel_q;
    vidx_d     = vidx_q;
    cnt_d      = cnt_q;
    vend_d     = vend_q;
    rej_d      = 1'b0;
    deny_d     = 1'b0;
    coin_block = 1'b0;
    coin_add   = '0;
`ifdef VEND_CHANGE_RETURN_EN
    chg_d      = '0;
`endif

    // Highest-index coin wins; any other simultaneous coin is refused.
    for (int i = 0; i < 4; i++) begin
      if (coin_ev[i]) coin_add = SUM_W'(COIN_VAL[i]);
    end
    coin_multi = (coin_ev & (coin_ev - 4'd1)) != 4'd0;
    coin_sum   = {1'b0, credit_q} + coin_add;

    case (state_q)
      IDLE: begin
`ifdef VEND_CHANGE_RETURN_EN
        if (f_ev && credit_q != '0) begin
          state_d    = CHANGE;
          coin_block = 1'b1;
        end else
`endif
        if (afford != '0) state_d = SELECT;
      end
      SELECT: begin
        if (l_ev && !r_ev)
          sel_d = (sel_q == '0) ? IDX_W'(N_ITEMS - 1) : sel_q - IDX_W'(1);
        else if (r_ev && !l_ev)
          sel_d = (sel_q == IDX_W'(N_ITEMS - 1)) ? '0 : sel_q + IDX_W'(1);
        if (c_ev && can_buy) begin
          credit_d   = credit_q - CREDIT_W'(cur_price);
          vidx_d     = sel_q;
          vend_d     = 1'b1;
          cnt_d      = CNT_W'(VEND_CYCLES - 1);
          state_d    = VEND;
          coin_block = 1'b1;
        end else if (c_ev) begin
          deny_d = 1'b1;
`ifdef VEND_CHANGE_RETURN_EN
        end else if (f_ev && credit_q != '0) begin
          state_d    = CHANGE;
          coin_block = 1'b1;
`endif
        end else if (afford == '0) begin
          state_d = IDLE;
        end
      end
      VEND: begin
        coin_block = 1'b1;
        if (cnt_q == '0) begin
          vend_d  = 1'b0;
          state_d = (afford != '0) ? SELECT : IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef VEND_CHANGE_RETURN_EN
      CHANGE: begin
        coin_block = 1'b1;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (credit_q >= CREDIT_W'(COIN_VAL[i])) begin
              chg_d    = 4'b0001 << i;
              credit_d = credit_q - CREDIT_W'(COIN_VAL[i]);
            end
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (coin_ev != '0) begin
      if (coin_block) begin
        rej_d = 1'b1;
      end else begin
        if (coin_sum <= SUM_W'(MAX_CREDIT)) credit_d = coin_sum[CREDIT_W-1:0];
        rej_d = coin_multi || (coin_sum > SUM_W'(MAX_CREDIT));
      end
    end
  end

endmodule
